sdc_port: RTL and testbench
===========================

# sdc_port

Bridges the 8-bit CPU memory port, after bank translation into a 25-bit byte address, onto the 32-bit request/acknowledge port of the SDRAM controller. Each CPU access becomes exactly one controller transaction. Byte accesses are steered onto the correct lane with byte enables, and read data is extracted back to 8 bits. `sdc_busy` stalls the CPU, and a watchdog aborts reads the controller never answers. The block sits directly downstream of the bank-translation stage and directly upstream of the SDRAM controller.

## Interface
Parameters:
- `TIMEOUT`, default 1023: max cycles waited for `ctl_rvalid` after `ctl_ack` on a read.
- `TW`, default 10: watchdog counter width; `TIMEOUT` < 2^`TW`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `sdc_addr`  in  25  byte address from bank translation.
- `sdc_data_in`  in  32  write data; only [7:0] used.
- `sdc_cs_reg`  in  1  access select.
- `sdc_rd_reg`  in  1  read strobe.
- `sdc_wr_reg`  in  1  write strobe.
- `sdc_busy`  out  1  registered; access in progress, CPU must stall.
- `sdc_data_out`  out  8  last read byte; held until next read completes.
- `sdc_err`  out  1  last read timed out.
- `ctl_req`  out  1  transaction request, held until `ctl_ack`.
- `ctl_we`  out  1  1 = write, 0 = read; stable while `ctl_req`.
- `ctl_addr`  out  23  word address = `sdc_addr[24:2]`.
- `ctl_be`  out  4  byte enables, one-hot from `sdc_addr[1:0]`.
- `ctl_wdata`  out  32  `sdc_data_in[7:0]` replicated on all four lanes.
- `ctl_ack`  in  1  one-cycle acceptance of the current request.
- `ctl_rvalid`  in  1  one-cycle read-data valid.
- `ctl_rdata`  in  32  read data, valid with `ctl_rvalid`.

## Operation
- Accept condition: `sdc_cs_reg && (sdc_rd_reg ^ sdc_wr_reg) && !sdc_busy` in state IDLE.
  - `rd` and `wr` both high: ignored, no transaction.
  - The CPU pulses strobes for one cycle. A strobe still held in the cycle after accept is masked by `sdc_busy`.
- On accept, latch the following: `ctl_addr` from `sdc_addr[24:2]`, `ctl_be = 4'b0001 << sdc_addr[1:0]`, `ctl_wdata = {4{sdc_data_in[7:0]}}`, `ctl_we = wr`, lane select = `sdc_addr[1:0]`, and clear `sdc_err`.
- FSM states: IDLE, REQ, RWAIT, DONE.
  - IDLE -> REQ on accept.
  - REQ: `ctl_req=1`; on `ctl_ack`, go to DONE if write, RWAIT if read. There is no timeout in REQ; the controller must eventually ack.
  - RWAIT: the watchdog counts up from 0 each cycle.
    - On `ctl_rvalid`: `sdc_data_out <= ctl_rdata[8*lane +: 8]`, go to DONE.
    - If the count reaches `TIMEOUT` first: `sdc_data_out <= 8'hFF`, `sdc_err <= 1`, go to DONE.
  - DONE -> IDLE unconditionally.
- `sdc_busy = (state != IDLE)`, registered.
- `ctl_rvalid` outside RWAIT (e.g. late data after a timeout) is discarded; `sdc_data_out` is unchanged.
- `ctl_ack` outside REQ is ignored.
- A reset in any state returns the block to IDLE in the next cycle and drops `ctl_req` immediately, even mid-handshake.

## Timing
- Reset values: `sdc_busy=0`, `sdc_data_out=8'h00`, `sdc_err=0`, `ctl_req=0`, `ctl_we=0`, `ctl_addr=0`, `ctl_be=0`, `ctl_wdata=0`, FSM=IDLE, watchdog=0.
- Accept at cycle T: `ctl_req` and `sdc_busy` go high at T+1.
- Ack at cycle A:
  - `ctl_req` is low at A+1.
  - Write: `sdc_busy` is low at A+2, giving a minimum write occupancy of 3 cycles with ack at T+1.
- `ctl_rvalid` at cycle R: `sdc_data_out` is valid at R+1 and `sdc_busy` is low at R+2.
- Timeout: the watchdog reaches `TIMEOUT` on the `TIMEOUT`-th RWAIT cycle. `sdc_err`, `8'hFF` and the DONE state appear the next cycle.
- If `ctl_rvalid` arrives in the same cycle the count hits `TIMEOUT`, `rvalid` wins: data is latched and no error is flagged.
- Next accept is possible in the first cycle `sdc_busy=0`, so back-to-back accesses are spaced by at least 3 cycles.

## Structure
- Shared package `sdc_pkg`:
  - FSM state enum.
  - `SDC_AW=25`, `CTL_AW=23`, `CTL_DW=32`.
  - Lane-select and byte-enable helper functions, also used by the controller model in the bench.
- A single module with no sub-modules. The watchdog counter is inline.

## Test plan
- Write `sdc_addr=25'h0001236`, data `8'h5A`, ack after 2 cycles -> `ctl_addr=23'h00048D`, `ctl_be=4'b0100`, `ctl_wdata=32'h5A5A5A5A`, `ctl_we=1`, `sdc_busy` low 2 cycles after ack.
- Read `sdc_addr=25'h1FFFFFF`, `rdata=32'hA1B2C3D4` 5 cycles after ack -> `ctl_be=4'b1000`, `sdc_data_out=8'hA1`, `sdc_err=0`.
- Read with no `rvalid` (`TIMEOUT=16`) -> `sdc_data_out=8'hFF`, `sdc_err=1`. A late `rvalid` of `32'h11` is ignored. The next successful read clears `sdc_err`.
- `rd` and `wr` high together, then `rd` held high 3 cycles -> first: no `ctl_req`; second: exactly one transaction.
- Reset asserted while in REQ and while in RWAIT -> next cycle `ctl_req=0`, `sdc_busy=0`, all outputs at reset values; a subsequent access completes normally.
- `rvalid` coincident with timeout expiry -> data latched, `sdc_err=0`.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared types, widths and lane helpers for the CPU-to-SDRAM-controller bridge.
package sdc_pkg;

  localparam int SDC_AW = 25;  // CPU byte address width
  localparam int CTL_AW = 23;  // controller word address width
  localparam int CTL_DW = 32;  // controller data width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } sdc_state_e;

  // Byte lane within the 32-bit word addressed by a CPU byte address.
  function automatic logic [1:0] lane_sel(input logic [SDC_AW-1:0] addr);
    return addr[1:0];
  endfunction

  // One-hot byte enable for a lane.
  function automatic logic [3:0] byte_en(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Pull one byte out of a controller word.
  function automatic logic [7:0] extract_byte(input logic [CTL_DW-1:0] word,
                                              input logic [1:0]        lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/sdc_if.sv
// Request/acknowledge port of the SDRAM controller. master = bridge, slave = controller.
interface sdc_if;
  import sdc_pkg::*;

  logic              ctl_req;
  logic              ctl_we;
  logic [CTL_AW-1:0] ctl_addr;
  logic [3:0]        ctl_be;
  logic [CTL_DW-1:0] ctl_wdata;
  logic              ctl_ack;
  logic              ctl_rvalid;
  logic [CTL_DW-1:0] ctl_rdata;

  modport master (
    output ctl_req, ctl_we, ctl_addr, ctl_be, ctl_wdata,
    input  ctl_ack, ctl_rvalid, ctl_rdata
  );

  modport slave (
    input  ctl_req, ctl_we, ctl_addr, ctl_be, ctl_wdata,
    output ctl_ack, ctl_rvalid, ctl_rdata
  );
endinterface

// File: rtl/sdc_port.sv
// Turns each 8-bit CPU access into one 32-bit controller transaction.
// Writes are lane-steered with byte enables; reads extract the addressed byte.
// A watchdog aborts reads whose data never arrives and flags sdc_err.
module sdc_port
  import sdc_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SDC_AW-1:0] sdc_addr,
  input  logic [CTL_DW-1:0] sdc_data_in,
  input  logic              sdc_cs_reg,
  input  logic              sdc_rd_reg,
  input  logic              sdc_wr_reg,
  output logic              sdc_busy,
  output logic [7:0]        sdc_data_out,
  output logic              sdc_err,
  sdc_if.master             ctl
);

  localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);

  sdc_state_e        r_state;
  logic              r_busy;
  logic [7:0]        r_dout;
  logic              r_err;
  logic              r_req;
  logic              r_we;
  logic [CTL_AW-1:0] r_addr;
  logic [3:0]        r_be;
  logic [CTL_DW-1:0] r_wdata;
  logic [1:0]        r_lane;
  logic [TW-1:0]     r_wd;

  logic              w_accept;
  logic [TW-1:0]     w_wd_inc;
  logic              w_unused_ok;

  // Only the low byte of the write data is meaningful on an 8-bit CPU.
  assign w_unused_ok = ^sdc_data_in[CTL_DW-1:8];

  // rd and wr together are treated as a malformed strobe and ignored.
  assign w_accept = sdc_cs_reg && (sdc_rd_reg ^ sdc_wr_reg) && !r_busy;
  // r_wd counts completed RWAIT cycles, so w_wd_inc is the current cycle's count.
  assign w_wd_inc = r_wd + TW'(1);

  // Transaction FSM with all outputs registered; rvalid has priority over timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_dout  <= 8'h00;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_lane  <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= sdc_addr[SDC_AW-1:2];
            r_be    <= byte_en(lane_sel(sdc_addr));
            r_wdata <= {4{sdc_data_in[7:0]}};
            r_we    <= sdc_wr_reg;
            r_lane  <= lane_sel(sdc_addr);
            r_err   <= 1'b0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ctl.ctl_ack) begin
            r_req   <= 1'b0;
            r_wd    <= '0;
            r_state <= r_we ? ST_DONE : ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (ctl.ctl_rvalid) begin
            r_dout  <= extract_byte(ctl.ctl_rdata, r_lane);
            r_state <= ST_DONE;
          end else if (w_wd_inc == LP_TIMEOUT) begin
            r_dout  <= 8'hFF;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wd    <= w_wd_inc;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdc_busy      = r_busy;
  assign sdc_data_out  = r_dout;
  assign sdc_err       = r_err;
  assign ctl.ctl_req   = r_req;
  assign ctl.ctl_we    = r_we;
  assign ctl.ctl_addr  = r_addr;
  assign ctl.ctl_be    = r_be;
  assign ctl.ctl_wdata = r_wdata;

endmodule

// File: tb/tb_sdc_port.sv
// Directed bench for sdc_port: a vector table of complete accesses plus
// hand-written sequences for strobe masking and mid-transaction reset.
module tb_sdc_port;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] sdc_addr;
  logic [31:0] sdc_data_in;
  logic        sdc_cs_reg, sdc_rd_reg, sdc_wr_reg;
  logic        sdc_busy;
  logic [7:0]  sdc_data_out;
  logic        sdc_err;

  sdc_if u_if ();

  sdc_port #(.TIMEOUT(TO), .TW(10)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .sdc_addr     (sdc_addr),
    .sdc_data_in  (sdc_data_in),
    .sdc_cs_reg   (sdc_cs_reg),
    .sdc_rd_reg   (sdc_rd_reg),
    .sdc_wr_reg   (sdc_wr_reg),
    .sdc_busy     (sdc_busy),
    .sdc_data_out (sdc_data_out),
    .sdc_err      (sdc_err),
    .ctl          (u_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Count rising edges of ctl_req to prove one transaction per access.
  int   req_rises = 0;
  logic req_prev  = 1'b0;
  always @(negedge clk) begin
    if (u_if.ctl_req && !req_prev) req_rises++;
    req_prev = u_if.ctl_req;
  end

  typedef struct {
    logic        wr;
    logic [24:0] addr;
    logic [31:0] din;
    int          ack_dly;  // REQ cycles before ack
    int          rv_dly;   // rvalid this many cycles after ack; <0 = never
    logic [31:0] rdata;
    logic [22:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [7:0]  e_dout;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [24:0] addr, logic [31:0] din,
                              int ack_dly, int rv_dly, logic [31:0] rdata,
                              logic [22:0] e_addr, logic [3:0] e_be,
                              logic [31:0] e_wdata, logic [7:0] e_dout, logic e_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.din = din; v.ack_dly = ack_dly; v.rv_dly = rv_dly;
    v.rdata = rdata; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_dout = e_dout; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},   32'(u_if.ctl_req),   32'h0);
    chk({tag, ".busy"},  32'(sdc_busy),       32'h0);
    chk({tag, ".dout"},  32'(sdc_data_out),   32'h0);
    chk({tag, ".err"},   32'(sdc_err),        32'h0);
    chk({tag, ".we"},    32'(u_if.ctl_we),    32'h0);
    chk({tag, ".addr"},  32'(u_if.ctl_addr),  32'h0);
    chk({tag, ".be"},    32'(u_if.ctl_be),    32'h0);
    chk({tag, ".wdata"}, u_if.ctl_wdata,      32'h0);
  endtask

  // Drive one CPU access through to completion, acting as the controller.
  task automatic run_vec(input vec_t v, input string tag);
    sdc_cs_reg = 1'b1; sdc_rd_reg = !v.wr; sdc_wr_reg = v.wr;
    sdc_addr = v.addr; sdc_data_in = v.din;
    tick();
    sdc_cs_reg = 1'b0; sdc_rd_reg = 1'b0; sdc_wr_reg = 1'b0;
    chk({tag, ".req"},   32'(u_if.ctl_req),  32'h1);
    chk({tag, ".busy"},  32'(sdc_busy),      32'h1);
    chk({tag, ".addr"},  32'(u_if.ctl_addr), 32'(v.e_addr));
    chk({tag, ".be"},    32'(u_if.ctl_be),   32'(v.e_be));
    chk({tag, ".wdata"}, u_if.ctl_wdata,     v.e_wdata);
    chk({tag, ".we"},    32'(u_if.ctl_we),   32'(v.wr));
    chk({tag, ".errclr"}, 32'(sdc_err),      32'h0);
    repeat (v.ack_dly) tick();
    chk({tag, ".reqhold"}, 32'(u_if.ctl_req), 32'h1);
    u_if.ctl_ack = 1'b1;
    tick();
    u_if.ctl_ack = 1'b0;
    chk({tag, ".reqdrop"}, 32'(u_if.ctl_req), 32'h0);
    if (!v.wr) begin
      if (v.rv_dly > 0) begin
        repeat (v.rv_dly - 1) tick();
        u_if.ctl_rvalid = 1'b1; u_if.ctl_rdata = v.rdata;
        tick();
        u_if.ctl_rvalid = 1'b0; u_if.ctl_rdata = '0;
      end else begin
        repeat (TO - 1) tick();
        chk({tag, ".preexp_err"},  32'(sdc_err),  32'h0);
        chk({tag, ".preexp_busy"}, 32'(sdc_busy), 32'h1);
        tick();
      end
    end
    chk({tag, ".done_busy"}, 32'(sdc_busy),     32'h1);
    chk({tag, ".dout"},      32'(sdc_data_out), 32'(v.e_dout));
    chk({tag, ".err"},       32'(sdc_err),      32'(v.e_err));
    tick();
    chk({tag, ".idle_busy"}, 32'(sdc_busy),     32'h0);
    if (v.rv_dly < 0 && !v.wr) begin
      // Late data after an abort must not touch the held byte.
      u_if.ctl_rvalid = 1'b1; u_if.ctl_rdata = 32'h0000_0011;
      tick();
      u_if.ctl_rvalid = 1'b0; u_if.ctl_rdata = '0;
      chk({tag, ".late_dout"}, 32'(sdc_data_out), 32'(v.e_dout));
      chk({tag, ".late_err"},  32'(sdc_err),      32'h1);
    end
  endtask

  vec_t vecs[7];
  int   rises0;

  initial begin
    reset = 1'b1;
    sdc_addr = '0; sdc_data_in = '0;
    sdc_cs_reg = 1'b0; sdc_rd_reg = 1'b0; sdc_wr_reg = 1'b0;
    u_if.ctl_ack = 1'b0; u_if.ctl_rvalid = 1'b0; u_if.ctl_rdata = '0;

    //            wr    addr          din           ack rv  rdata         e_addr       e_be     e_wdata       dout   err
    vecs[0] = mk(1'b1, 25'h0001236, 32'hDEADBE5A, 2,  0, 32'h0,        23'h00048D, 4'b0100, 32'h5A5A5A5A, 8'h00, 1'b0);
    vecs[1] = mk(1'b0, 25'h1FFFFFF, 32'hFFFFFF33, 1,  5, 32'hA1B2C3D4, 23'h7FFFFF, 4'b1000, 32'h33333333, 8'hA1, 1'b0);
    vecs[2] = mk(1'b0, 25'h0000001, 32'h0,        0,  1, 32'h11223344, 23'h000000, 4'b0010, 32'h00000000, 8'h33, 1'b0);
    vecs[3] = mk(1'b0, 25'h0ABCDE4, 32'h0,        3, -1, 32'h0,        23'h2AF379, 4'b0001, 32'h00000000, 8'hFF, 1'b1);
    vecs[4] = mk(1'b0, 25'h0000002, 32'h0,        0, TO, 32'h00C30000, 23'h000000, 4'b0100, 32'h00000000, 8'hC3, 1'b0);
    vecs[5] = mk(1'b1, 25'h1000003, 32'h000000A7, 0,  0, 32'h0,        23'h400000, 4'b1000, 32'hA7A7A7A7, 8'hC3, 1'b0);
    vecs[6] = mk(1'b0, 25'h0000000, 32'h0,        0,  1, 32'hFFFFFF00, 23'h000000, 4'b0001, 32'h00000000, 8'h00, 1'b0);

    repeat (2) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // rd and wr together: no transaction.
    rises0 = req_rises;
    sdc_cs_reg = 1'b1; sdc_rd_reg = 1'b1; sdc_wr_reg = 1'b1; sdc_addr = 25'h0000010;
    tick();
    sdc_cs_reg = 1'b0; sdc_rd_reg = 1'b0; sdc_wr_reg = 1'b0;
    chk("both.req",  32'(u_if.ctl_req), 32'h0);
    chk("both.busy", 32'(sdc_busy),     32'h0);
    tick();
    chk("both.rises", 32'(req_rises - rises0), 32'h0);

    // rd held for three cycles: the extra cycles are masked by busy.
    rises0 = req_rises;
    sdc_cs_reg = 1'b1; sdc_rd_reg = 1'b1; sdc_addr = 25'h0000004;
    tick();
    chk("hold.req", 32'(u_if.ctl_req), 32'h1);
    tick();
    u_if.ctl_ack = 1'b1;
    tick();
    u_if.ctl_ack = 1'b0;
    sdc_cs_reg = 1'b0; sdc_rd_reg = 1'b0;
    u_if.ctl_rvalid = 1'b1; u_if.ctl_rdata = 32'h000000BE;
    tick();
    u_if.ctl_rvalid = 1'b0; u_if.ctl_rdata = '0;
    chk("hold.dout", 32'(sdc_data_out), 32'h0000_00BE);
    repeat (4) tick();
    chk("hold.req_after", 32'(u_if.ctl_req), 32'h0);
    chk("hold.rises", 32'(req_rises - rises0), 32'h1);

    // Reset while in REQ.
    sdc_cs_reg = 1'b1; sdc_wr_reg = 1'b1; sdc_addr = 25'h0000008; sdc_data_in = 32'h77;
    tick();
    sdc_cs_reg = 1'b0; sdc_wr_reg = 1'b0;
    chk("rstreq.pre", 32'(u_if.ctl_req), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rstreq");
    run_vec(mk(1'b0, 25'h0000105, 32'h0, 1, 2, 32'h0000_9900, 23'h000041, 4'b0010,
               32'h0, 8'h99, 1'b0), "after_rstreq");

    // Reset while in RWAIT.
    sdc_cs_reg = 1'b1; sdc_rd_reg = 1'b1; sdc_addr = 25'h000000C;
    tick();
    sdc_cs_reg = 1'b0; sdc_rd_reg = 1'b0;
    u_if.ctl_ack = 1'b1;
    tick();
    u_if.ctl_ack = 1'b0;
    repeat (2) tick();
    chk("rstrw.pre_busy", 32'(sdc_busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rstrw");
    run_vec(mk(1'b0, 25'h0000013, 32'h0, 0, 3, 32'h4D00_0000, 23'h000004, 4'b1000,
               32'h0, 8'h4D, 1'b0), "after_rstrw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Whole run is a few hundred cycles; this only guards against a stuck bench.
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
